// File: rtl/conv_core_array.sv
// conv_core_array: K x K convolution engine, NUM_CH output channels in parallel.
// Each channel keeps two K*K signed weight banks: the shadow bank loads one tap
// per wt_valid cycle (row-major) while the active bank feeds the multipliers.
// Writing the last tap swaps the banks on that same edge.
// Two-stage pipeline: S1 registers all products, S2 sums / shifts / saturates.
// Build option: define RELU_EN to clamp negative results to zero in S2.
module conv_core_array #(
  parameter int WIDTH  = 8,
  parameter int K      = 3,
  parameter int NUM_CH = 4,
  parameter int SHIFT  = 0,
  parameter int ACC_W  = 2*WIDTH + $clog2(K*K)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wt_valid,
  input  logic [NUM_CH*WIDTH-1:0]   wt_in,
  output logic                      wt_load_done,
  output logic                      wt_ready,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [K*K*WIDTH-1:0]      act_win,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*WIDTH-1:0]   out_psum
);

  localparam int TAPS   = K*K;
  localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2*WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0]  wt_q [2][NUM_CH][TAPS];
  logic signed [WIDTH-1:0]  wt_d [2][NUM_CH][TAPS];
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     bank_q, bank_d;
  logic                     wt_ready_q, wt_ready_d;
  logic                     wt_load_done_q, wt_load_done_d;

  logic signed [PROD_W-1:0] prod_q [NUM_CH][TAPS];
  logic signed [PROD_W-1:0] prod_d [NUM_CH][TAPS];
  logic                     s1_valid_q, s1_valid_d;

  logic                     out_valid_q, out_valid_d;
  logic [NUM_CH*WIDTH-1:0]  out_psum_q, out_psum_d;

  logic signed [WIDTH-1:0]  act_tap [TAPS];
  logic signed [WIDTH-1:0]  sat_res [NUM_CH];
  logic                     shadow_bank;
  logic                     s2_stall;
  logic                     s1_adv;
  logic                     act_fire;

  assign shadow_bank  = ~bank_q;
  assign s2_stall     = out_valid_q & ~out_ready;
  assign s1_adv       = ~s1_valid_q | ~s2_stall;
  assign act_ready    = wt_ready_q & s1_adv;
  assign act_fire     = act_valid & act_ready;

  assign wt_ready     = wt_ready_q;
  assign wt_load_done = wt_load_done_q;
  assign out_valid    = out_valid_q;
  assign out_psum     = out_psum_q;

  // Split the flat activation window into signed taps.
  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      act_tap[t] = act_win[t*WIDTH +: WIDTH];
    end
  end

  // Serial shadow-bank load; the last tap swaps banks and flags the set complete.
  always_comb begin
    wt_d           = wt_q;
    idx_d          = idx_q;
    bank_d         = bank_q;
    wt_ready_d     = wt_ready_q;
    wt_load_done_d = 1'b0;
    if (wt_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wt_d[shadow_bank][c][idx_q] = wt_in[c*WIDTH +: WIDTH];
      end
      if (idx_q == LAST_IDX) begin
        idx_d          = '0;
        bank_d         = ~bank_q;
        wt_ready_d     = 1'b1;
        wt_load_done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // S1: products use the bank active before this edge, so a window accepted
  // together with the final weight tap still sees the old set.
  always_comb begin
    s1_valid_d = s1_valid_q;
    prod_d     = prod_q;
    if (s1_adv) begin
      s1_valid_d = act_fire;
      if (act_fire) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int t = 0; t < TAPS; t++) begin
            prod_d[c][t] = PROD_W'(act_tap[t]) * PROD_W'(wt_q[bank_q][c][t]);
          end
        end
      end
    end
  end

  // S2 datapath: per-channel sum, arithmetic shift, saturation (optional ReLU).
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] res;
    for (int c = 0; c < NUM_CH; c++) begin
      acc = '0;
      for (int t = 0; t < TAPS; t++) begin
        acc = acc + ACC_W'(prod_q[c][t]);
      end
      acc = acc >>> SHIFT;
      if (acc > SAT_MAX) begin
        res = SAT_MAX[WIDTH-1:0];
      end else if (acc < SAT_MIN) begin
        res = SAT_MIN[WIDTH-1:0];
      end else begin
        res = acc[WIDTH-1:0];
      end
`ifdef RELU_EN
      if (res[WIDTH-1]) begin
        res = '0;
      end
`else
      res = res;
`endif
      sat_res[c] = res;
    end
  end

  // S2 register: advances unless the sink is holding off a valid result.
  always_comb begin
    out_valid_d = out_valid_q;
    out_psum_d  = out_psum_q;
    if (!s2_stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int c = 0; c < NUM_CH; c++) begin
          out_psum_d[c*WIDTH +: WIDTH] = sat_res[c];
        end
      end
    end
  end

  // State registers; reset clears weights and flushes the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int t = 0; t < TAPS; t++) begin
            wt_q[b][c][t] <= '0;
          end
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          prod_q[c][t] <= '0;
        end
      end
      idx_q          <= '0;
      bank_q         <= 1'b0;
      wt_ready_q     <= 1'b0;
      wt_load_done_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_psum_q     <= '0;
    end else begin
      wt_q           <= wt_d;
      prod_q         <= prod_d;
      idx_q          <= idx_d;
      bank_q         <= bank_d;
      wt_ready_q     <= wt_ready_d;
      wt_load_done_q <= wt_load_done_d;
      s1_valid_q     <= s1_valid_d;
      out_valid_q    <= out_valid_d;
      out_psum_q     <= out_psum_d;
    end
  end

endmodule

// File: tb/tb_conv_core_array.sv
// Directed bench for conv_core_array: a default instance (SHIFT=0) and a
// SHIFT=4 instance share all inputs; expected values are hand-computed.
module tb_conv_core_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wt_valid = 1'b0;
  logic [31:0] wt_in = '0;
  logic        act_valid = 1'b0;
  logic [71:0] act_win = '0;
  logic        out_ready = 1'b0;

  logic        wt_load_done, wt_ready, act_ready, out_valid;
  logic [31:0] out_psum;
  logic        wt_load_done_sh, wt_ready_sh, act_ready_sh, out_valid_sh;
  logic [31:0] out_psum_sh;

  int total = 0;
  int bad = 0;
  int ld_pulses = 0;
  bit mon_en = 1'b0;
  bit hold_chk = 1'b0;
  logic [31:0] held = '0;
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  conv_core_array dut (
    .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_in(wt_in),
    .wt_load_done(wt_load_done), .wt_ready(wt_ready),
    .act_valid(act_valid), .act_ready(act_ready), .act_win(act_win),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum)
  );

  conv_core_array #(.SHIFT(4)) dut_sh (
    .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_in(wt_in),
    .wt_load_done(wt_load_done_sh), .wt_ready(wt_ready_sh),
    .act_valid(act_valid), .act_ready(act_ready_sh), .act_win(act_win),
    .out_valid(out_valid_sh), .out_ready(out_ready), .out_psum(out_psum_sh)
  );

  typedef struct {
    int wt[4];
    int win[9];
    int em[4];
    int es[4];
  } vec_t;

  vec_t vecs[8];

  function automatic int rl(input int x);
`ifdef RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_wts(input int w[4], input int ntaps);
    for (int t = 0; t < ntaps; t++) begin
      wt_valid = 1'b1;
      for (int c = 0; c < 4; c++) wt_in[c*8 +: 8] = 8'(w[c]);
      tick();
    end
    wt_valid = 1'b0;
  endtask

  task automatic beat(input string nm, input int win[9], input int em[4], input int es[4]);
    logic signed [7:0] b;
    for (int t = 0; t < 9; t++) act_win[t*8 +: 8] = 8'(win[t]);
    act_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({nm, "_act_ready"}, {31'd0, act_ready}, 1);
    tick();
    act_valid = 1'b0;
    chk({nm, "_lat1_valid"}, {31'd0, out_valid}, 0);
    tick();
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 1);
    chk({nm, "_sh_valid"}, {31'd0, out_valid_sh}, 1);
    for (int c = 0; c < 4; c++) begin
      b = out_psum[c*8 +: 8];
      chk($sformatf("%s_ch%0d", nm, c), b, rl(em[c]));
      b = out_psum_sh[c*8 +: 8];
      chk($sformatf("%s_sh_ch%0d", nm, c), b, rl(es[c]));
    end
    tick();
  endtask

  // Negedge monitor: collect accepted results and check stalled outputs hold.
  always @(negedge clk) begin
    if (wt_load_done) ld_pulses++;
    if (mon_en) begin
      if (hold_chk) begin
        total++;
        if (out_valid !== 1'b1 || out_psum !== held) begin
          bad++;
          $display("FAIL hold: got v=%0b d=%h expected v=1 d=%h", out_valid, out_psum, held);
        end
      end
      hold_chk = out_valid && !out_ready;
      held = out_psum;
      if (out_valid && out_ready) got_q.push_back(out_psum);
    end else begin
      hold_chk = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, cyc;
    int w1[4], wn[9], e1[4], e2[4];
    int exp_sw[6];

    vecs[0].wt = '{1,1,1,1};       vecs[0].win = '{1,2,3,4,5,6,7,8,9};
    vecs[0].em = '{45,45,45,45};   vecs[0].es = '{2,2,2,2};
    vecs[1].wt = '{0,1,2,3};       vecs[1].win = '{2,2,2,2,2,2,2,2,2};
    vecs[1].em = '{0,18,36,54};    vecs[1].es = '{0,1,2,3};
    vecs[2].wt = '{127,127,127,127}; vecs[2].win = '{127,127,127,127,127,127,127,127,127};
    vecs[2].em = '{127,127,127,127}; vecs[2].es = '{127,127,127,127};
    vecs[3].wt = '{-128,-128,-128,-128}; vecs[3].win = '{127,127,127,127,127,127,127,127,127};
    vecs[3].em = '{-128,-128,-128,-128}; vecs[3].es = '{-128,-128,-128,-128};
    vecs[4].wt = '{1,-1,2,0};      vecs[4].win = '{1,-2,3,-4,5,-6,7,-8,9};
    vecs[4].em = '{5,-5,10,0};     vecs[4].es = '{0,-1,0,0};
    vecs[5].wt = '{3,-3,10,-10};   vecs[5].win = '{-1,-1,-1,-1,-1,-1,-1,-1,-1};
    vecs[5].em = '{-27,27,-90,90}; vecs[5].es = '{-2,1,-6,5};
    vecs[6].wt = '{-128,-128,-128,-128}; vecs[6].win = '{-128,-128,-128,-128,-128,-128,-128,-128,-128};
    vecs[6].em = '{127,127,127,127}; vecs[6].es = '{127,127,127,127};
    vecs[7].wt = '{4,4,4,4};       vecs[7].win = '{4,4,4,4,4,4,4,4,4};
    vecs[7].em = '{127,127,127,127}; vecs[7].es = '{9,9,9,9};

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_wt_ready", {31'd0, wt_ready}, 0);
    chk("rst_wt_load_done", {31'd0, wt_load_done}, 0);

    // No window accepted before a weight set exists.
    act_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("pre_load_act_ready", {31'd0, act_ready}, 0);
      tick();
    end
    act_valid = 1'b0;
    chk("pre_load_out_valid", {31'd0, out_valid}, 0);

    ld_pulses = 0;
    w1 = '{1,1,1,1};
    load_wts(w1, 8);
    chk("partial_wt_ready", {31'd0, wt_ready}, 0);
    load_wts(w1, 1);
    chk("first_load_done", {31'd0, wt_load_done}, 1);
    chk("first_wt_ready", {31'd0, wt_ready}, 1);
    chk("first_sh_wt_ready", {31'd0, wt_ready_sh}, 1);
    tick();
    tick();
    chk("first_load_pulses", ld_pulses, 1);
    chk("wt_ready_sticky", {31'd0, wt_ready}, 1);

    // Table of single-beat vectors, each with a fresh weight set.
    for (int i = 0; i < 8; i++) begin
      load_wts(vecs[i].wt, 9);
      chk($sformatf("v%0d_load_done", i), {31'd0, wt_load_done}, 1);
      chk($sformatf("v%0d_sh_load_done", i), {31'd0, wt_load_done_sh}, 1);
      beat($sformatf("v%0d", i), vecs[i].win, vecs[i].em, vecs[i].es);
    end

    // Partial reload must not disturb the active set (all 4s).
    ld_pulses = 0;
    load_wts(w1, 4);
    wn = '{1,1,1,1,1,1,1,1,1};
    e1 = '{36,36,36,36};
    e2 = '{2,2,2,2};
    beat("partial", wn, e1, e2);
    chk("partial_no_pulse", ld_pulses, 0);
    load_wts(w1, 5);
    chk("rest_load_done", {31'd0, wt_load_done}, 1);
    e1 = '{9,9,9,9};
    e2 = '{0,0,0,0};
    beat("completed", wn, e1, e2);

    // Backpressure: 10 windows, out_ready toggling 1,0,1,0...
    got_q.delete();
    mon_en = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      act_valid = 1'b1;
      act_win = {9{8'(k+1)}};
      @(negedge clk);
      if (act_ready) k++;
      tick();
      cyc++;
    end
    act_valid = 1'b0;
    chk("bp_sent", k, 10);
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    mon_en = 1'b0;
    chk("bp_count", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      chk($sformatf("bp_data%0d", i), got_q[i], {4{8'(9*(i+1))}});

    // Bank swap while streaming: reload 1 -> 2.
    got_q.delete();
    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wt_valid = (c <= 8);
      wt_in = {4{8'd2}};
      act_valid = (c >= 4 && c <= 9);
      act_win = {9{8'(c-3)}};
      tick();
    end
    wt_valid = 1'b0;
    act_valid = 1'b0;
    tick();
    tick();
    tick();
    mon_en = 1'b0;
    exp_sw = '{9, 18, 27, 36, 45, 108};
    chk("swap_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("swap_data%0d", i), got_q[i], {4{8'(exp_sw[i])}});

    // Reset with two beats in flight.
    out_ready = 1'b1;
    act_valid = 1'b1;
    act_win = {9{8'd1}};
    tick();
    act_win = {9{8'd2}};
    tick();
    act_valid = 1'b0;
    chk("inflight_valid", {31'd0, out_valid}, 1);
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_out_psum", out_psum, 0);
    chk("midrst_wt_ready", {31'd0, wt_ready}, 0);
    chk("midrst_act_ready", {31'd0, act_ready}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_output", {31'd0, out_valid}, 0);
    end
    w1 = '{3,3,3,3};
    load_wts(w1, 9);
    e1 = '{27,27,27,27};
    e2 = '{1,1,1,1};
    beat("after_rst", wn, e1, e2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
